systolic_mem_loader: RTL and testbench
======================================

// Module: systolic_mem_loader
// PURPOSE
//  Host-side counterpart of the systolic array controller on the shared single-port matrix memory.
//  - Writes operand matrices A and B into memory, then pulses new_data to start the array.
//  - Waits for the array to finish, then reads result matrix C back out.
//  - Host traffic uses valid/ready streams.
//  - Top level muxes the memory port between this block and the array controller using mem_grant.
// PARAMETERS
//  N       4   array dimension; legal matrix size is 1..N
//  WIDTH   16  signed element width
//  ADDR_W  12  memory address width
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous reset, active-low
//  start       in   1       1-cycle request to begin a load/compute/readback job; sampled only in IDLE
//  n           in   4       matrix size, sampled with start
//  addr_A      in   ADDR_W  base address of A, sampled with start
//  addr_B      in   ADDR_W  base address of B, sampled with start
//  addr_C      in   ADDR_W  base address of C, sampled with start
//  in_valid    in   1       host element valid
//  in_ready    out  1       loader accepts element
//  in_data     in   WIDTH   element, row-major: A first, then B
//  out_valid   out  1       C element valid
//  out_ready   in   1       host accepts C element
//  out_data    out  WIDTH   C element, row-major
//  out_last    out  1       marks final C element
//  mem_addr    out  ADDR_W  memory address
//  mem_wren    out  1       memory write enable
//  mem_wdata   out  WIDTH   memory write data
//  mem_rdata   in   WIDTH   memory read data; valid at the clk edge after mem_addr is driven (memory clocked on ~clk)
//  mem_grant   out  1       1 = loader owns the memory port; 0 = array controller owns it
//  new_data    out  1       1-cycle start pulse to the array controller
//  array_done  in   1       1-cycle completion pulse from the array controller
//  busy        out  1       high in every state except IDLE
//  err         out  1       sticky illegal-n flag; cleared by the next accepted legal start
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//   - State goes to IDLE; all outputs are 0 except mem_grant=1.
//   - Applies mid-job: any in-flight write is dropped and no new_data pulse is issued.
//  Job size: E = n*n elements per matrix.
//   - Element k of matrix X is at address base_X + k, modulo 2^ADDR_W (wraps, no error).
//  States
//   IDLE
//    - in_ready=0.
//    - On start: if n==0 or n>N, set err=1 and stay in IDLE; otherwise latch parameters, clear err and k, go to LOAD_A.
//   LOAD_A / LOAD_B
//    - in_ready=1.
//    - On an in_valid&in_ready handshake at cycle t: mem_addr=base+k, mem_wdata=in_data, mem_wren=1 during cycle t+1; k++.
//    - Full throughput: one element per cycle.
//    - After element E-1: LOAD_A goes to LOAD_B (k=0); LOAD_B goes to KICK.
//   KICK
//    - Holds one cycle so the last write completes.
//    - Next cycle: mem_grant=0 and new_data=1 for exactly 1 cycle; go to WAIT_ARRAY.
//   WAIT_ARRAY
//    - mem_grant=0, mem_wren=0.
//    - array_done=1 returns mem_grant to 1, sets k=0, goes to RD_ADDR.
//    - array_done in any other state is ignored.
//   RD_ADDR
//    - Drives mem_addr=base_C+k with mem_wren=0; go to RD_DATA.
//   RD_DATA
//    - Captures mem_rdata into out_data; out_valid=1; out_last=(k==E-1).
//    - out_data and out_last stay stable while out_valid&&!out_ready.
//    - On handshake: out_valid=0, k++; go to RD_ADDR, or to IDLE after the last element.
//    - Throughput: at most 1 element per 2 cycles.
//  Boundary conditions
//   - start outside IDLE is ignored; parameters latched at start do not change during the job.
//   - mem_wren is never 1 while mem_grant=0.
//   - new_data never pulses twice per job.
//   - n==1 gives E=1; out_last is set on the first C element.
// STRUCTURE
//  - Add to package SystolicTypes: loader_state_t enum {L_IDLE, L_LOAD_A, L_LOAD_B, L_KICK, L_WAIT, L_RD_ADDR, L_RD_DATA}.
//  - One sub-module: systolic_elem_counter (clear, incr, E input; k and last outputs), shared by the load and read phases.
// TESTING
//  1. rst=0 mid-LOAD_B -> next cycle IDLE, mem_wren=0, mem_grant=1, new_data never pulses.
//  2. n=2, addr_A=0x000, addr_B=0x010, addr_C=0x020, A=1,2,3,4, B=5,6,7,8 with in_valid held high
//     -> writes 0x000..0x003 then 0x010..0x013 on consecutive cycles; then one new_data pulse.
//     Memory model returns C=19,22,43,50 after array_done -> out_data 19,22,43,50, out_last only on 50.
//  3. start with n=0, then n=5 -> err=1, busy=0, no memory writes.
//     Then start with a legal n=1 -> err=0 and the job runs.
//  4. addr_A=0xFFE, n=2 -> writes to 0xFFE, 0xFFF, 0x000, 0x001.
//  5. out_ready held low for 5 cycles on C element 2 -> out_data stable, no new read address issued.
//     A spurious array_done during LOAD_A is ignored.

Source files
------------

// File: rtl/SystolicTypes.sv
// Shared types and sizing for the systolic-array host loader.
package SystolicTypes;

    // Width of the matrix-size port and of the element counter (holds n*n).
    localparam int N_W   = 4;
    localparam int CNT_W = 2 * N_W;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LOAD_A,
        L_LOAD_B,
        L_KICK,
        L_WAIT,
        L_RD_ADDR,
        L_RD_DATA
    } loader_state_t;

    // Number of elements in one n x n matrix.
    function automatic logic [CNT_W-1:0] elem_count(input logic [N_W-1:0] n);
        return CNT_W'(n) * CNT_W'(n);
    endfunction

endpackage

// File: rtl/systolic_elem_counter.sv
// Element index counter shared by the load and readback phases.
module systolic_elem_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         incr,
    input  logic [W-1:0] e,
    output logic [W-1:0] k,
    output logic         last
);

    // Clear has priority so a phase change can restart the index on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k <= '0;
        end else if (clear) begin
            k <= '0;
        end else if (incr) begin
            k <= k + W'(1);
        end
    end

    // Flags the final element of the current matrix.
    always_comb begin
        last = (k == (e - W'(1)));
    end

endmodule

// File: rtl/systolic_mem_loader.sv
// Host-side loader: writes A and B into the shared matrix memory, kicks the
// systolic array, waits for it, then streams C back to the host.
module systolic_mem_loader #(
    parameter int N      = 4,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic [ADDR_W-1:0] addr_C,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              mem_grant,
    output logic              new_data,
    input  logic              array_done,
    output logic              busy,
    output logic              err
);

    import SystolicTypes::*;

    loader_state_t      state;
    logic [CNT_W-1:0]   e_q;
    logic [ADDR_W-1:0]  base_a;
    logic [ADDR_W-1:0]  base_b;
    logic [ADDR_W-1:0]  base_c;

    logic [CNT_W-1:0]   k;
    logic               k_last;
    logic               k_clear;
    logic               k_incr;
    logic               n_legal;
    logic               in_hs;
    logic               out_hs;

    systolic_elem_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (k_clear),
        .incr  (k_incr),
        .e     (e_q),
        .k     (k),
        .last  (k_last)
    );

    // Handshakes, size legality and counter control derived from the current state.
    always_comb begin
        n_legal = (n != '0) && (32'(n) <= N);
        in_hs   = in_valid && in_ready;
        out_hs  = out_valid && out_ready;
        k_clear = 1'b0;
        k_incr  = 1'b0;
        case (state)
            L_IDLE:    k_clear = start && n_legal;
            L_LOAD_A:  begin
                k_clear = in_hs && k_last;
                k_incr  = in_hs;
            end
            L_LOAD_B:  k_incr  = in_hs;
            L_WAIT:    k_clear = array_done;
            L_RD_DATA: k_incr  = out_hs;
            default:   ;
        endcase
    end

    // Job sequencer with registered outputs; writes land one cycle after their handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= L_IDLE;
            e_q       <= '0;
            base_a    <= '0;
            base_b    <= '0;
            base_c    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            mem_addr  <= '0;
            mem_wren  <= 1'b0;
            mem_wdata <= '0;
            mem_grant <= 1'b1;
            new_data  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            new_data <= 1'b0;
            case (state)
                L_IDLE: begin
                    if (start) begin
                        if (!n_legal) begin
                            err <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            e_q      <= elem_count(n);
                            base_a   <= addr_A;
                            base_b   <= addr_B;
                            base_c   <= addr_C;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= L_LOAD_A;
                        end
                    end
                end
                L_LOAD_A: begin
                    if (in_hs) begin
                        mem_wren  <= 1'b1;
                        mem_addr  <= base_a + ADDR_W'(k);
                        mem_wdata <= in_data;
                        if (k_last) begin
                            state <= L_LOAD_B;
                        end
                    end
                end
                L_LOAD_B: begin
                    if (in_hs) begin
                        mem_wren  <= 1'b1;
                        mem_addr  <= base_b + ADDR_W'(k);
                        mem_wdata <= in_data;
                        if (k_last) begin
                            in_ready <= 1'b0;
                            state    <= L_KICK;
                        end
                    end
                end
                L_KICK: begin
                    mem_grant <= 1'b0;
                    new_data  <= 1'b1;
                    state     <= L_WAIT;
                end
                L_WAIT: begin
                    if (array_done) begin
                        mem_grant <= 1'b1;
                        mem_addr  <= base_c;
                        state     <= L_RD_ADDR;
                    end
                end
                L_RD_ADDR: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    out_last  <= k_last;
                    state     <= L_RD_DATA;
                end
                L_RD_DATA: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (k_last) begin
                            busy  <= 1'b0;
                            state <= L_IDLE;
                        end else begin
                            mem_addr <= base_c + ADDR_W'(k) + ADDR_W'(1);
                            state    <= L_RD_ADDR;
                        end
                    end
                end
                default: state <= L_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mem_loader.sv
// Directed scoreboard bench for systolic_mem_loader.
module tb_systolic_mem_loader;

    localparam int N      = 4;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 12;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        n;
    logic [ADDR_W-1:0] addr_A;
    logic [ADDR_W-1:0] addr_B;
    logic [ADDR_W-1:0] addr_C;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_grant;
    logic              new_data;
    logic              array_done;
    logic              busy;
    logic              err;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int nd_count = 0;

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    int  wr_cyc[$];

    always #5 clk = ~clk;

    systolic_mem_loader #(
        .N      (N),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n          (n),
        .addr_A     (addr_A),
        .addr_B     (addr_B),
        .addr_C     (addr_C),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .mem_addr   (mem_addr),
        .mem_wren   (mem_wren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_grant  (mem_grant),
        .new_data   (new_data),
        .array_done (array_done),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Single-port memory clocked on the falling edge.
    always @(negedge clk) begin
        if (mem_wren === 1'b1) mem[mem_addr] = mem_wdata;
        mem_rdata = mem[mem_addr];
    end

    // Write scoreboard and new_data pulse counter.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (new_data === 1'b1) nd_count++;
        if (mem_wren === 1'b1) begin
            check("wren_grant", 32'(mem_grant), 32'd1);
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(mem_wren), 32'd0);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nn, input logic [ADDR_W-1:0] aa,
                            input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] ac);
        n      = 4'(nn);
        addr_A = aa;
        addr_B = ab;
        addr_C = ac;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic run_job(input int nn, input logic [ADDR_W-1:0] aa,
                           input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] ac,
                           input int off, input int stall_idx, input int stall_n,
                           input bit spurious);
        int  e;
        int  t;
        int  s;
        int  av[16];
        int  bv[16];
        rd_t r;
        e = nn * nn;
        wr_cyc.delete();
        nd_count = 0;
        for (int k = 0; k < e; k++) begin
            av[k] = off + k + 1;
            bv[k] = off + e + k + 1;
        end
        for (int k = 0; k < e; k++) exp_wr.push_back('{addr: ADDR_W'(aa + k), data: WIDTH'(av[k])});
        for (int k = 0; k < e; k++) exp_wr.push_back('{addr: ADDR_W'(ab + k), data: WIDTH'(bv[k])});

        do_start(nn, aa, ab, ac);
        @(negedge clk);
        check("start_err", 32'(err), 32'd0);
        check("start_busy", 32'(busy), 32'd1);

        for (int k = 0; k < 2 * e; k++) begin
            in_valid   = 1'b1;
            in_data    = (k < e) ? WIDTH'(av[k]) : WIDTH'(bv[k - e]);
            array_done = spurious && (k == 1);
            start      = spurious && (k == 2);
            n          = (spurious && (k == 2)) ? 4'd0 : 4'(nn);
            addr_A     = (spurious && (k == 2)) ? 12'hABC : aa;
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        array_done = 1'b0;
        start      = 1'b0;
        n          = 4'(nn);
        addr_A     = aa;

        t = 0;
        while (new_data !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("new_data", 32'(new_data), 32'd1);
        check("grant_wait", 32'(mem_grant), 32'd0);
        check("wr_pending", 32'(exp_wr.size()), 32'd0);
        check("wr_count", 32'(wr_cyc.size()), 32'(2 * e));
        for (int i = 1; i < wr_cyc.size(); i++) check("wr_consec", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd1);

        // Array side: compute C = A*B and deposit it while the loader is off the port.
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < nn; j++) begin
                s = 0;
                for (int l = 0; l < nn; l++) s += av[i*nn + l] * bv[l*nn + j];
                mem[ADDR_W'(ac + i*nn + j)] = WIDTH'(s);
                exp_rd.push_back('{data: WIDTH'(s), last: (i*nn + j == e - 1)});
            end
        end
        repeat (3) @(negedge clk);
        check("new_data_once", 32'(new_data), 32'd0);
        check("grant_hold", 32'(mem_grant), 32'd0);
        array_done = 1'b1;
        @(negedge clk);
        array_done = 1'b0;

        for (int k = 0; k < e; k++) begin
            out_ready = (k != stall_idx);
            t = 0;
            while (out_valid !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("out_valid", 32'(out_valid), 32'd1);
            r = exp_rd.pop_front();
            check("out_data", 32'(out_data), 32'(r.data));
            check("out_last", 32'(out_last), 32'(r.last));
            check("rd_addr", 32'(mem_addr), 32'(ADDR_W'(ac + k)));
            check("rd_grant", 32'(mem_grant), 32'd1);
            if (k == stall_idx) begin
                repeat (stall_n) begin
                    @(negedge clk);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(r.data));
                    check("stall_last", 32'(out_last), 32'(r.last));
                    check("stall_addr", 32'(mem_addr), 32'(ADDR_W'(ac + k)));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            check("out_valid_drop", 32'(out_valid), 32'd0);
        end

        check("end_busy", 32'(busy), 32'd0);
        check("end_grant", 32'(mem_grant), 32'd1);
        check("end_err", 32'(err), 32'd0);
        check("nd_count", 32'(nd_count), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        n          = 4'd0;
        addr_A     = '0;
        addr_B     = '0;
        addr_C     = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        array_done = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_mem_wren", 32'(mem_wren), 32'd0);
        check("rst_mem_grant", 32'(mem_grant), 32'd1);
        check("rst_new_data", 32'(new_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Reset while loading B: B0 lands, the concurrent B1 handshake is dropped.
        nd_count = 0;
        for (int k = 0; k < 4; k++) exp_wr.push_back('{addr: ADDR_W'(12'h040 + k), data: WIDTH'(100 + k)});
        exp_wr.push_back('{addr: 12'h050, data: 16'd200});
        do_start(2, 12'h040, 12'h050, 12'h060);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = (k < 4) ? WIDTH'(100 + k) : 16'd200;
            step();
        end
        in_data = 16'd201;
        rst     = 1'b0;
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wren", 32'(mem_wren), 32'd0);
        check("midrst_grant", 32'(mem_grant), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (10) @(negedge clk);
        check("midrst_nd", 32'(nd_count), 32'd0);
        check("midrst_pending", 32'(exp_wr.size()), 32'd0);
        check("midrst_wren_late", 32'(mem_wren), 32'd0);
        step();

        // Reference 2x2 job: C = 19,22,43,50.
        run_job(2, 12'h000, 12'h010, 12'h020, 0, -1, 0, 1'b0);
        step();

        // Illegal sizes set err without starting anything; legal n=1 clears it.
        do_start(0, 12'h080, 12'h090, 12'h0A0);
        @(negedge clk);
        check("n0_err", 32'(err), 32'd1);
        check("n0_busy", 32'(busy), 32'd0);
        step();
        do_start(5, 12'h080, 12'h090, 12'h0A0);
        @(negedge clk);
        check("n5_err", 32'(err), 32'd1);
        check("n5_busy", 32'(busy), 32'd0);
        check("n5_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("n5_wren", 32'(mem_wren), 32'd0);
        step();
        run_job(1, 12'h080, 12'h090, 12'h0A0, 4, -1, 0, 1'b0);
        step();

        // Address wrap on A and on C.
        run_job(2, 12'hFFE, 12'h100, 12'hFFF, -3, -1, 0, 1'b0);
        step();

        // Back-pressure on C element 2, spurious array_done and start mid-load.
        run_job(3, 12'h200, 12'h300, 12'h400, 7, 2, 5, 1'b1);
        step();

        // Largest legal matrix.
        run_job(4, 12'h500, 12'h600, 12'h700, -8, 15, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
